// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
// Owns the shared multiply/divide unit for the decode/execute stage. A mult or
// div seen in DX while idle is captured. The sequencer then sends one start
// pulse with the latched operands to the unit. It stalls the front of the
// pipeline until the unit is ready, then emits one writeback. The writeback
// goes either to rd with the result, or to $30 with an exception status code.
//
// Optional feature: define MD_WATCHDOG_EN to add a WAIT-state watchdog. It
// forces a writeback of TIMEOUT_CODE to $30 once the counter reaches TIMEOUT-1.
//
// Ports:
//   clock, reset            - clock; asynchronous active-high reset
//   dx_isMult, dx_isDiv     - DX instruction kind (mult wins when both set)
//   dx_opA, dx_opB, dx_rd   - forwarded operands and destination register
//   md_ctrlMult, md_ctrlDiv - one-cycle start pulses to the multdiv unit
//   md_opA, md_opB          - operands latched at capture
//   md_result, md_exception - unit outputs, valid while md_ready is high
//   md_ready                - unit done (level, only looked at in WAIT)
//   stall, busy             - sequencer not idle
//   wb_valid, wb_rd, wb_data - one-cycle writeback to the MW stage
module multdiv_sequencer #(
  parameter int TIMEOUT       = 40,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5,
  parameter int TIMEOUT_CODE  = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_isMult,
  input  logic        dx_isDiv,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic [4:0]  dx_rd,
  output logic        md_ctrlMult,
  output logic        md_ctrlDiv,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        timeout_flag;

`ifdef MD_WATCHDOG_EN
  localparam logic [5:0] COUNT_LAST = 6'(TIMEOUT - 1);
  logic [5:0] count_q, count_d;
  logic       timeout_q, timeout_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MD_WATCHDOG_EN
      count_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef MD_WATCHDOG_EN
      count_q   <= count_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    result_d = result_q;
    exc_d    = exc_q;
`ifdef MD_WATCHDOG_EN
    count_d   = count_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (dx_isMult || dx_isDiv) begin
          op_a_d   = dx_opA;
          op_b_d   = dx_opB;
          rd_d     = dx_rd;
          is_div_d = ~dx_isMult;
`ifdef MD_WATCHDOG_EN
          timeout_d = 1'b0;
`endif
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
`ifdef MD_WATCHDOG_EN
        count_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (md_ready) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = WB;
        end else begin
`ifdef MD_WATCHDOG_EN
          // md_ready in the same cycle takes priority over expiry.
          if (count_q == COUNT_LAST) begin
            timeout_d = 1'b1;
            exc_d     = 1'b0;
            state_d   = WB;
          end
          // Saturate rather than wrap.
          if (count_q != 6'h3f) begin
            count_d = count_q + 6'd1;
          end
`endif
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MD_WATCHDOG_EN
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  // All outputs are decoded from registered state, so reset clears them at once.
  always_comb begin
    md_ctrlMult = (state_q == ISSUE) && !is_div_q;
    md_ctrlDiv  = (state_q == ISSUE) && is_div_q;
    md_opA      = op_a_q;
    md_opB      = op_b_q;
    busy        = (state_q != IDLE);
    stall       = (state_q != IDLE);
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    if (state_q == WB) begin
      if (timeout_flag) begin
        wb_valid = 1'b1;
        wb_rd    = 5'd30;
        wb_data  = 32'(TIMEOUT_CODE);
      end else if (exc_q) begin
        wb_valid = 1'b1;
        wb_rd    = 5'd30;
        wb_data  = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
      end else begin
        // A result destined for r0 is dropped; the state still passes WB.
        wb_valid = (rd_q != 5'd0);
        wb_rd    = rd_q;
        wb_data  = result_q;
      end
    end
  end

endmodule
